mem_port_arbiter: RTL

- Shares the single-port 32x16 memory between two requesters: the program loader (port L) and the CPU core (port C).
- Selects one requester per cycle and muxes its address, write-data and write-enable onto the memory port.
- Returns registered read data with a one-cycle-later valid strobe to the requester that issued the read.
- Adds an exclusive load mode, so a program image is written without CPU interference, and a starvation guard for the CPU in normal mode.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter_pkg: shared widths, arbiter states and defaults      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE            = 16;
  localparam int MEM_ADDR_SIZE        = 5;
  localparam int MEM_SIZE             = 32;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic {
    ARB_RUN  = 1'b0,
    ARB_LOAD = 1'b1
  } arb_state_e;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between loader and CPU      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_done,
  output logic                     load_busy,
  input  logic                     ld_req,
  input  logic                     ld_we,
  input  logic [MEM_ADDR_SIZE-1:0] ld_addr,
  input  logic [WORD_SIZE-1:0]     ld_wdata,
  output logic                     ld_gnt,
  output logic                     ld_rvalid,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]     cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [WORD_SIZE-1:0]     rdata,
  output logic                     mem_we,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  input  logic [WORD_SIZE-1:0]     mem_rdata
);

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             ld_rvalid_q, ld_rvalid_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;

  always_comb begin
    ld_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    // Grants are gated by reset so nothing reaches memory while held in reset.
    if (reset) begin
      if (state_q == ARB_LOAD) begin
        ld_gnt = ld_req;
      end else if (cpu_req && (starve_cnt_q == C_LIMIT)) begin
        cpu_gnt = 1'b1;
      end else begin
        ld_gnt  = ld_req;
        cpu_gnt = cpu_req & ~ld_req;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = 4'd0;
    ld_rvalid_d  = ld_gnt & ~ld_we;
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    case (state_q)
      ARB_RUN:  if (load_start) state_d = ARB_LOAD;
      ARB_LOAD: if (load_done)  state_d = ARB_RUN;
      default:  state_d = ARB_RUN;
    endcase
    if ((state_q == ARB_RUN) && cpu_req && !cpu_gnt) begin
      starve_cnt_d = (starve_cnt_q < C_LIMIT) ? starve_cnt_q + 4'd1 : starve_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ARB_RUN;
      starve_cnt_q <= 4'd0;
      ld_rvalid_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      ld_rvalid_q  <= ld_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign load_busy  = (state_q == ARB_LOAD);
  assign ld_rvalid  = ld_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign rdata      = mem_rdata;

endmodule : mem_port_arbiter
`default_nettype wire
